// File: rtl/lab5_pio_out_pulse.sv
// ---------------------------------------------------------------------------
// lab5_pio_out_pulse : Avalon-MM output PIO with set/clear, timed pulses, status
// Optional macro LAB5_PIO_OUT_BITSET_EN enables OUTSET/OUTCLEAR.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lab5_pio_out_pulse #(
  parameter int unsigned DATA_WIDTH      = 10,
  parameter logic [31:0] RESET_VALUE     = 32'h0,
  parameter int unsigned PULSE_CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [31:0]           readdata,
  output logic                  pulse_busy
);

  localparam logic [DATA_WIDTH-1:0]      RST_DATA = RESET_VALUE[DATA_WIDTH-1:0];
  localparam logic [PULSE_CNT_WIDTH-1:0] LEN_ONE  = PULSE_CNT_WIDTH'(1);
  localparam logic [7:0]                 WIDTH_ID = 8'(DATA_WIDTH);
`ifdef LAB5_PIO_OUT_BITSET_EN
  localparam logic                       BITSET   = 1'b1;
`else
  localparam logic                       BITSET   = 1'b0;
`endif

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e                     state_q;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic [DATA_WIDTH-1:0]      mask_q;
  logic [PULSE_CNT_WIDTH-1:0] len_q;
  logic [PULSE_CNT_WIDTH-1:0] cnt_q;

  logic                       wr;
  logic                       pulse_req;
  logic [DATA_WIDTH-1:0]      wd;
  logic [PULSE_CNT_WIDTH-1:0] load_cnt;
  logic                       unused_ok;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[DATA_WIDTH-1:0];
  assign pulse_req = wr && (address == 3'd4) && (wd != '0);
  // A stored length of 0 behaves as a 1-cycle pulse.
  assign load_cnt  = (len_q == '0) ? '0 : len_q - LEN_ONE;
  assign unused_ok = ^writedata;

  always_comb begin
    data_d = data_q;
    if (wr) begin
      case (address)
        3'd0: data_d = wd;
`ifdef LAB5_PIO_OUT_BITSET_EN
        3'd2: data_d = data_q | wd;
        3'd3: data_d = data_q & ~wd;
`endif
        default: data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= RST_DATA;
      len_q   <= LEN_ONE;
      mask_q  <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      data_q <= data_d;
      if (wr && (address == 3'd1)) begin
        len_q <= writedata[PULSE_CNT_WIDTH-1:0];
      end
      case (state_q)
        IDLE: begin
          if (pulse_req) begin
            mask_q  <= wd;
            cnt_q   <= load_cnt;
            state_q <= ACTIVE;
          end
        end
        ACTIVE: begin
          // A new request beats expiry and restarts the full length.
          if (pulse_req) begin
            mask_q <= mask_q | wd;
            cnt_q  <= load_cnt;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - LEN_ONE;
          end else begin
            mask_q  <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_port   = data_q | mask_q;
  assign pulse_busy = (state_q == ACTIVE);

  always_comb begin
    readdata = 32'h0;
    case (address)
      3'd0: readdata = 32'(data_q);
      3'd1: readdata = 32'(len_q);
      3'd4: readdata = 32'(mask_q);
      3'd5: readdata = {16'h0, WIDTH_ID, 6'h0, BITSET, pulse_busy};
      default: readdata = 32'h0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_lab5_pio_out_pulse.sv
// ---------------------------------------------------------------------------
// tb_lab5_pio_out_pulse : vector table, corner sequences and random vs model
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lab5_pio_out_pulse;

`ifdef LAB5_PIO_OUT_BITSET_EN
  localparam bit BITSET = 1'b1;
`else
  localparam bit BITSET = 1'b0;
`endif
  localparam logic [9:0] RV = 10'h2A5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [9:0]  out_port;
  logic [31:0] readdata;
  logic        pulse_busy;

  int n_checks = 0;
  int n_fail   = 0;

  lab5_pio_out_pulse #(
    .DATA_WIDTH(10),
    .RESET_VALUE(32'h2A5),
    .PULSE_CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .out_port(out_port),
    .readdata(readdata),
    .pulse_busy(pulse_busy)
  );

  always #5 clk = ~clk;

  // Reference model: pulse tracked as "cycles still visible".
  logic [9:0]  m_data;
  logic [9:0]  m_mask;
  int unsigned m_len;
  int unsigned m_left;

  task automatic mreset();
    m_data = RV;
    m_mask = '0;
    m_len  = 1;
    m_left = 0;
  endtask

  task automatic model_step(input logic cs, input logic wn, input logic [2:0] a,
                            input logic [31:0] d);
    logic       w;
    logic [9:0] m;
    w = cs && !wn;
    m = d[9:0];
    if (reset_n) begin
      if (w && a == 3'd4 && m != 10'h0) begin
        m_mask = ((m_left > 0) ? m_mask : 10'h0) | m;
        m_left = (m_len == 0) ? 1 : m_len;
      end else if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mask = '0;
      end
      if (w) begin
        case (a)
          3'd0: m_data = m;
          3'd1: m_len  = int'(d[15:0]);
          3'd2: if (BITSET) m_data = m_data | m;
          3'd3: if (BITSET) m_data = m_data & ~m;
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [31:0] mread(input logic [2:0] a);
    case (a)
      3'd0: return {22'h0, m_data};
      3'd1: return m_len;
      3'd4: return {22'h0, m_mask};
      3'd5: return {16'h0, 8'd10, 6'h0, BITSET, (m_left > 0)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic cs, input logic wn, input logic [2:0] a,
                      input logic [31:0] d);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    @(posedge clk);
    model_step(cs, wn, a, d);
    #1;
  endtask

  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [9:0]  eout;
    logic        ebusy;
    logic [31:0] erd;
  } vec_t;

  vec_t        tv[24];
  logic [9:0]  dv, dv1;
  logic [31:0] stat;

  initial begin
    mreset();
    dv   = BITSET ? 10'h302 : 10'h003;
    dv1  = BITSET ? 10'h303 : 10'h003;
    stat = 32'h0000_0A00 | (32'(BITSET) << 1);

    tv[0]  = '{1'b1, 1'b0, 3'd0, 32'hFFFF_F003, 10'h003, 1'b0, 32'h003};
    tv[1]  = '{1'b1, 1'b1, 3'd0, 32'h0, 10'h003, 1'b0, 32'h003};
    tv[2]  = '{1'b1, 1'b0, 3'd2, 32'h300, dv1, 1'b0, 32'h0};
    tv[3]  = '{1'b1, 1'b0, 3'd3, 32'h001, dv, 1'b0, 32'h0};
    tv[4]  = '{1'b1, 1'b0, 3'd1, 32'h3, dv, 1'b0, 32'h3};
    tv[5]  = '{1'b1, 1'b0, 3'd4, 32'h010, dv | 10'h010, 1'b1, 32'h010};
    tv[6]  = '{1'b0, 1'b1, 3'd4, 32'h0, dv | 10'h010, 1'b1, 32'h010};
    tv[7]  = '{1'b0, 1'b1, 3'd4, 32'h0, dv | 10'h010, 1'b1, 32'h010};
    tv[8]  = '{1'b0, 1'b1, 3'd4, 32'h0, dv, 1'b0, 32'h0};
    tv[9]  = '{1'b1, 1'b0, 3'd1, 32'h0, dv, 1'b0, 32'h0};
    tv[10] = '{1'b1, 1'b0, 3'd4, 32'h004, dv | 10'h004, 1'b1, 32'h004};
    tv[11] = '{1'b0, 1'b1, 3'd4, 32'h0, dv, 1'b0, 32'h0};
    tv[12] = '{1'b1, 1'b0, 3'd4, 32'h0, dv, 1'b0, 32'h0};
    tv[13] = '{1'b1, 1'b1, 3'd5, 32'h0, dv, 1'b0, stat};
    tv[14] = '{1'b1, 1'b0, 3'd6, 32'hFFFF_FFFF, dv, 1'b0, 32'h0};
    tv[15] = '{1'b1, 1'b0, 3'd0, 32'h0, 10'h000, 1'b0, 32'h0};
    tv[16] = '{1'b1, 1'b0, 3'd1, 32'h4, 10'h000, 1'b0, 32'h4};
    tv[17] = '{1'b1, 1'b0, 3'd4, 32'h001, 10'h001, 1'b1, 32'h001};
    tv[18] = '{1'b0, 1'b1, 3'd4, 32'h0, 10'h001, 1'b1, 32'h001};
    tv[19] = '{1'b1, 1'b0, 3'd4, 32'h002, 10'h003, 1'b1, 32'h003};
    tv[20] = '{1'b0, 1'b1, 3'd4, 32'h0, 10'h003, 1'b1, 32'h003};
    tv[21] = '{1'b0, 1'b1, 3'd4, 32'h0, 10'h003, 1'b1, 32'h003};
    tv[22] = '{1'b0, 1'b1, 3'd4, 32'h0, 10'h003, 1'b1, 32'h003};
    tv[23] = '{1'b0, 1'b1, 3'd4, 32'h0, 10'h000, 1'b0, 32'h000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset out_port", {22'h0, out_port}, {22'h0, RV});
    check("reset busy", {31'h0, pulse_busy}, 32'h0);
    address = 3'd1;
    #1;
    check("reset pulse_len", readdata, 32'h1);
    address = 3'd5;
    #1;
    check("reset status", readdata, stat);
    reset_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      step(tv[i].cs, tv[i].wn, tv[i].addr, tv[i].wd);
      check($sformatf("vec%0d out", i), {22'h0, out_port}, {22'h0, tv[i].eout});
      check($sformatf("vec%0d busy", i), {31'h0, pulse_busy}, {31'h0, tv[i].ebusy});
      check($sformatf("vec%0d rd", i), readdata, tv[i].erd);
    end

    // Asynchronous reset in the middle of a pulse
    step(1'b1, 1'b0, 3'd1, 32'h5);
    step(1'b1, 1'b0, 3'd4, 32'h0FF);
    check("pre-reset out", {22'h0, out_port}, 32'h0FF);
    step(1'b0, 1'b1, 3'd4, 32'h0);
    #3;
    reset_n = 1'b0;
    mreset();
    #1;
    check("async reset out", {22'h0, out_port}, {22'h0, RV});
    check("async reset busy", {31'h0, pulse_busy}, 32'h0);
    step(1'b0, 1'b1, 3'd4, 32'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 3'd4, 32'h0);
      check("post-reset out", {22'h0, out_port}, {22'h0, RV});
      check("post-reset busy", {31'h0, pulse_busy}, 32'h0);
      check("post-reset mask", readdata, 32'h0);
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic        cs, wn;
      logic [2:0]  a;
      logic [31:0] d;
      cs = ($urandom % 4) != 0;
      wn = $urandom % 2;
      a  = 3'($urandom_range(0, 7));
      d  = $urandom;
      if (a == 3'd1) d = $urandom_range(0, 5);
      if (a == 3'd4 && ($urandom % 3) == 0) d = 32'h0;
      step(cs, wn, a, d);
      check("rand out", {22'h0, out_port}, {22'h0, m_data | m_mask});
      check("rand busy", {31'h0, pulse_busy}, {31'h0, (m_left > 0)});
      check("rand rd", readdata, mread(a));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
